proc_core_param: RTL and testbench
==================================

# proc_core_param

Parametrised successor to the 16-bit multicycle bus CPU. It keeps the same shared-bus datapath of registers, A/G accumulator pair, 2-bit step counter and instruction register, but width, register count and opcode set are parameters. It adds AND and conditional move (MVNZ), an illegal-opcode error flag and a debug read port. The block is the processor core of the design: it fetches instructions and immediates from `din` under `run` and reports completion on `done`.

## Interface
- `DATA_W`, 16: register, bus and ALU width; must be ≥ `3 + 2*REG_AW`.
- `NREGS`, 8: number of general registers; power of two, 2..16.
- `REG_AW`, $clog2(NREGS): derived register-address width; do not override.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  instruction-valid; sampled only in step T0.
- `din`  in  DATA_W  instruction word in T0, immediate in T1 of MVI.
- `dbg_sel`  in  REG_AW  debug register select.
- `buswires`  out  DATA_W  current shared-bus value (combinational).
- `done`  out  1  high for exactly the final step of each instruction.
- `err`  out  1  high with `done` when the opcode is illegal.
- `dbg_data`  out  DATA_W  contents of register `dbg_sel` (combinational).

## Operation
- Instruction format, taken from `din` LSBs: op = [2*REG_AW+2 : 2*REG_AW], rx = [2*REG_AW-1 : REG_AW], ry = [REG_AW-1 : 0]. Upper bits are ignored.
- Opcodes:
  - 000 MV: rx←ry.
  - 001 MVI: rx←din.
  - 010 ADD: rx←rx+ry.
  - 011 SUB: rx←rx−ry.
  - 100 AND: rx←rx&ry.
  - 101 MVNZ: rx←ry if G≠0.
  - 110 and 111: illegal.
- Steps (2-bit counter):
  - T0: if `run`, IR←din and go to T1; else stay in T0 with the bus idle.
  - T1, MV: bus=ry, write rx, `done`, go to T0.
  - T1, MVI: bus=din, write rx, `done`, go to T0.
  - T1, MVNZ: bus=ry, write rx only if G≠0, `done` always, go to T0.
  - T1, ADD/SUB/AND: bus=rx, A←bus, go to T2.
  - T1, illegal: `done`=`err`=1, no writes, go to T0.
  - T2: bus=ry, G←A op bus, go to T3.
  - T3: bus=G, write rx, `done`, go to T0.
- Arithmetic is modulo 2^DATA_W; there is no carry or overflow output. SUB is A + ~bus + 1.
- G persists between instructions. MVNZ tests the G left by the last ALU op.
- Bus mux priority: din (MVI T1) > G (T3) > register selected by the step's select. In T0 the bus shows r0.
- rx = ry is legal in every opcode, e.g. SUB r2,r2 gives 0.
- `run` deasserted mid-instruction has no effect; the instruction completes.

## Timing
- Reset values: all registers, A, G and IR are 0; step is T0; `done`=0; `err`=0; `buswires`=0.
- `reset` has priority over every write on the same edge. Reset mid-instruction aborts it with no register write and no `done`.
- Latency from the T0 accept edge: MV/MVI/MVNZ/illegal assert `done` in the next cycle (2 cycles total); ALU ops assert it 3 cycles later (4 cycles total).
- Back-to-back: the cycle after `done` is T0, so with `run` held the next instruction is accepted immediately. Throughput is 2 or 4 cycles per instruction.
- `done` and `err` are combinational from step/IR (and G for nothing). They are glitch-free at the clock edge and valid for the whole step.
- The register write, A and G updates take effect on the edge that ends the step.

## Structure
- Package `proc_pkg` holds:
  - opcode localparams (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_MVNZ);
  - the step encoding T0..T3;
  - a function for the one-hot register write decode.
- Sub-module `proc_regfile` provides NREGS×DATA_W registers with a one-hot write enable, a bus-select read port and a debug read port.
- The step counter, control decode, A/G and ALU stay in the top level.

## Test plan
- Defaults; reset; MVI r1,0x0005; MVI r2,0x0003; ADD r1,r2 → `done` at cycles 2,4,8 after start; r1=0x0008, visible on `dbg_data` with `dbg_sel`=1.
- SUB r3,r3 after MVI r3,0x0000 then SUB r3,r1 with r1=1 → r3=0xFFFF (wrap). AND r3,r1 → 0x0001.
- MVNZ with G=0 straight after reset → rx unchanged and `done`=1. After an ADD giving a nonzero G → rx←ry.
- Opcode 110 → `done`=`err`=1 in T1, no register changes, next instruction accepted the following cycle.
- `reset` asserted in T2 of an ADD → no write to rx, `done` never pulses, all registers 0, step T0 after the edge.
- DATA_W=32, NREGS=16: MVI r15,0xDEADBEEF; MV r0,r15 → r0=0xDEADBEEF; `run` dropped during T1 does not stall completion.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the parametrised multicycle bus processor:
// opcodes, step encoding and the register write-enable decoder.
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVNZ = 3'b101;

    // Upper bound on NREGS; the decoder is sized for it and callers slice.
    localparam int MAX_REGS = 16;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    function automatic logic [MAX_REGS-1:0] reg_onehot(input logic [3:0] idx,
                                                        input logic       en);
        logic [MAX_REGS-1:0] dec;
        dec = '0;
        if (en) begin
            dec[idx] = 1'b1;
        end
        return dec;
    endfunction

endpackage

// File: rtl/proc_regfile.sv
// General register file: NREGS x DATA_W, one-hot write enable, one read
// port feeding the shared bus and one independent debug read port.
import proc_pkg::*;

module proc_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREGS-1:0]  we,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] rd_sel,
    output logic [DATA_W-1:0] rd_data,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (we[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    assign rd_data  = regs[rd_sel];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/proc_core_param.sv
// Parametrised multicycle bus CPU: step counter, control decode, A/G
// accumulator pair and ALU around a shared bus and proc_regfile.
import proc_pkg::*;

module proc_core_param #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] buswires,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int IR_W = 2 * REG_AW + 3;

    step_t               step_q;
    step_t               step_d;
    logic [IR_W-1:0]     ir;
    logic [2:0]          op;
    logic [REG_AW-1:0]   rx;
    logic [REG_AW-1:0]   ry;

    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   g_reg;
    logic [DATA_W-1:0]   alu_out;
    logic [DATA_W-1:0]   rf_rd_data;

    logic [REG_AW-1:0]   bus_sel;
    logic                din_sel;
    logic                g_sel;
    logic                ir_en;
    logic                a_en;
    logic                g_en;
    logic                wr_en;

    logic [MAX_REGS-1:0] we_full;
    logic [NREGS-1:0]    rf_we;
    logic                we_unused;

    assign op = ir[2*REG_AW+2 -: 3];
    assign rx = ir[2*REG_AW-1 -: REG_AW];
    assign ry = ir[REG_AW-1:0];

    // Step register, instruction register and accumulators; reset wins over
    // every update so an aborted instruction leaves no trace.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= T0;
            ir     <= '0;
            a_reg  <= '0;
            g_reg  <= '0;
        end else begin
            step_q <= step_d;
            if (ir_en) begin
                ir <= din[IR_W-1:0];
            end
            if (a_en) begin
                a_reg <= buswires;
            end
            if (g_en) begin
                g_reg <= alu_out;
            end
        end
    end

    always_comb begin
        step_d  = step_q;
        bus_sel = '0;
        din_sel = 1'b0;
        g_sel   = 1'b0;
        ir_en   = 1'b0;
        a_en    = 1'b0;
        g_en    = 1'b0;
        wr_en   = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (step_q)
            T0: begin
                if (run) begin
                    ir_en  = 1'b1;
                    step_d = T1;
                end
            end
            T1: begin
                step_d = T0;
                case (op)
                    OP_MV: begin
                        bus_sel = ry;
                        wr_en   = 1'b1;
                        done    = 1'b1;
                    end
                    OP_MVI: begin
                        din_sel = 1'b1;
                        wr_en   = 1'b1;
                        done    = 1'b1;
                    end
                    OP_MVNZ: begin
                        bus_sel = ry;
                        wr_en   = (g_reg != '0);
                        done    = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        bus_sel = rx;
                        a_en    = 1'b1;
                        step_d  = T2;
                    end
                    default: begin
                        done = 1'b1;
                        err  = 1'b1;
                    end
                endcase
            end
            T2: begin
                bus_sel = ry;
                g_en    = 1'b1;
                step_d  = T3;
            end
            T3: begin
                g_sel  = 1'b1;
                wr_en  = 1'b1;
                done   = 1'b1;
                step_d = T0;
            end
            default: begin
                step_d = T0;
            end
        endcase
    end

    // SUB is done as A + ~bus + 1 so the adder is shared with ADD.
    always_comb begin
        case (op)
            OP_SUB:  alu_out = a_reg + ~buswires + DATA_W'(1);
            OP_AND:  alu_out = a_reg & buswires;
            default: alu_out = a_reg + buswires;
        endcase
    end

    always_comb begin
        if (din_sel) begin
            buswires = din;
        end else if (g_sel) begin
            buswires = g_reg;
        end else begin
            buswires = rf_rd_data;
        end
    end

    assign we_full   = reg_onehot(4'(rx), wr_en);
    assign rf_we     = we_full[NREGS-1:0];
    assign we_unused = ^we_full;

    proc_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .wdata    (buswires),
        .rd_sel   (bus_sel),
        .rd_data  (rf_rd_data),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_proc_core_param.sv
// Self-checking bench for proc_core_param: a 16-bit/8-register and a
// 32-bit/16-register instance checked against an instruction-level model.
import proc_pkg::*;

module tb_proc_core_param;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic        reset;
    logic        run16, run32;
    logic [15:0] din16;
    logic [31:0] din32;
    logic [2:0]  dbg16;
    logic [3:0]  dbg32;
    logic [15:0] bus16, dd16;
    logic [31:0] bus32, dd32;
    logic        done16, err16, done32, err32;

    proc_core_param #(.DATA_W(16), .NREGS(8)) dut16 (
        .clk      (clk),
        .reset    (reset),
        .run      (run16),
        .din      (din16),
        .dbg_sel  (dbg16),
        .buswires (bus16),
        .done     (done16),
        .err      (err16),
        .dbg_data (dd16)
    );

    proc_core_param #(.DATA_W(32), .NREGS(16)) dut32 (
        .clk      (clk),
        .reset    (reset),
        .run      (run32),
        .din      (din32),
        .dbg_sel  (dbg32),
        .buswires (bus32),
        .done     (done32),
        .err      (err32),
        .dbg_data (dd32)
    );

    int          vectors = 0;
    int          miscompares = 0;
    bit          wide = 1'b0;
    logic [31:0] mreg [16];
    logic [31:0] mg;

    logic        cdone, cerr;
    logic [31:0] cbus, cdbg;

    assign cdone = wide ? done32 : done16;
    assign cerr  = wide ? err32  : err16;
    assign cbus  = wide ? bus32  : {16'h0, bus16};
    assign cdbg  = wide ? dd32   : {16'h0, dd16};

    function automatic int nregs();
        return wide ? 16 : 8;
    endfunction

    function automatic logic [31:0] mask();
        return wide ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    // Random upper bits exercise the "upper instruction bits ignored" rule.
    function automatic logic [31:0] encode(input logic [2:0] op, input int rx, input int ry);
        logic [31:0] w;
        w = $urandom;
        if (wide) w[10:0] = {op, 4'(rx), 4'(ry)};
        else      w[8:0]  = {op, 3'(rx), 3'(ry)};
        return w;
    endfunction

    task automatic drive(input logic r, input logic [31:0] d);
        if (wide) begin
            run32 = r;
            din32 = d;
            run16 = 1'b0;
        end else begin
            run16 = r;
            din16 = d[15:0];
            run32 = 1'b0;
        end
    endtask

    task automatic set_dbg(input int r);
        if (wide) dbg32 = 4'(r);
        else      dbg16 = 3'(r);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mreg[i] = '0;
        mg = '0;
    endtask

    task automatic compare_regs(input string tag);
        for (int i = 0; i < nregs(); i++) begin
            set_dbg(i);
            #1;
            vectors++;
            if (cdbg !== mreg[i]) begin
                miscompares++;
                $display("[TB] FAIL %s_r%0d: got %h expected %h", tag, i, cdbg, mreg[i]);
            end
        end
    endtask

    // Issues one instruction from T0, checks latency, err and bus at the done
    // step, then checks every register on the cycle after done (back in T0).
    task automatic exec(input logic [2:0] op, input int rx, input int ry,
                        input logic [31:0] imm, input bit drop_run);
        logic [31:0] a, b, exp_bus;
        int          exp_lat, cyc;
        bit          illegal;
        a       = mreg[rx];
        b       = mreg[ry];
        exp_bus = b;
        exp_lat = 1;
        illegal = 1'b0;
        case (op)
            OP_MV:   mreg[rx] = b;
            OP_MVI:  begin exp_bus = imm & mask(); mreg[rx] = exp_bus; end
            OP_ADD:  begin mg = (a + b) & mask(); mreg[rx] = mg; exp_bus = mg; exp_lat = 3; end
            OP_SUB:  begin mg = (a - b) & mask(); mreg[rx] = mg; exp_bus = mg; exp_lat = 3; end
            OP_AND:  begin mg = a & b;            mreg[rx] = mg; exp_bus = mg; exp_lat = 3; end
            OP_MVNZ: if (mg != 0) mreg[rx] = b;
            default: illegal = 1'b1;
        endcase

        drive(1'b1, encode(op, rx, ry));
        #1;
        vectors++;
        if (cdone !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL done_in_t0 op=%0d: got %b expected 0", op, cdone);
        end
        @(posedge clk);
        @(negedge clk);
        if (op == OP_MVI) drive(!drop_run, imm);
        else              drive(drop_run ? 1'b0 : 1'($urandom), $urandom);
        #1;
        cyc = 1;
        while (cdone !== 1'b1 && cyc < 8) begin
            @(posedge clk);
            @(negedge clk);
            drive(drop_run ? 1'b0 : 1'($urandom), $urandom);
            #1;
            cyc++;
        end
        vectors++;
        if (cyc != exp_lat) begin
            miscompares++;
            $display("[TB] FAIL latency op=%0d: got %0d cycles expected %0d", op, cyc, exp_lat);
        end
        vectors++;
        if (cerr !== illegal) begin
            miscompares++;
            $display("[TB] FAIL err op=%0d: got %b expected %b", op, cerr, illegal);
        end
        if (!illegal) begin
            vectors++;
            if (cbus !== exp_bus) begin
                miscompares++;
                $display("[TB] FAIL bus_at_done op=%0d: got %h expected %h", op, cbus, exp_bus);
            end
        end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, $urandom);
        compare_regs("regs");
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, '0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (cdone !== 1'b0 || cerr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got done=%b err=%b expected 0 0", cdone, cerr);
        end
        vectors++;
        if (cbus !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_bus: got %h expected 0", cbus);
        end
        compare_regs("reset");
    endtask

    task automatic test_basic();
        exec(OP_MVI, 1, 0, 32'h0005, 1'b0);
        exec(OP_MVI, 2, 0, 32'h0003, 1'b0);
        exec(OP_ADD, 1, 2, 32'h0, 1'b0);
        set_dbg(1);
        #1;
        vectors++;
        if (cdbg !== 32'h8) begin
            miscompares++;
            $display("[TB] FAIL add_result_r1: got %h expected 8", cdbg);
        end
    endtask

    task automatic test_sub_wrap();
        exec(OP_MVI, 3, 0, 32'h0, 1'b0);
        exec(OP_SUB, 3, 3, 32'h0, 1'b0);
        exec(OP_MVI, 1, 0, 32'h1, 1'b0);
        exec(OP_SUB, 3, 1, 32'h0, 1'b0);
        set_dbg(3);
        #1;
        vectors++;
        if (cdbg !== 32'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL sub_wrap_r3: got %h expected ffff", cdbg);
        end
        exec(OP_AND, 3, 1, 32'h0, 1'b0);
        set_dbg(3);
        #1;
        vectors++;
        if (cdbg !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL and_r3: got %h expected 1", cdbg);
        end
    endtask

    task automatic test_mvnz();
        test_reset();
        exec(OP_MVI, 1, 0, 32'h0007, 1'b0);
        exec(OP_MVNZ, 4, 1, 32'h0, 1'b0);
        exec(OP_ADD, 1, 1, 32'h0, 1'b0);
        exec(OP_MVNZ, 4, 1, 32'h0, 1'b0);
        set_dbg(4);
        #1;
        vectors++;
        if (cdbg !== 32'hE) begin
            miscompares++;
            $display("[TB] FAIL mvnz_taken_r4: got %h expected e", cdbg);
        end
    endtask

    task automatic test_illegal();
        exec(3'b110, 2, 5, 32'h0, 1'b0);
        exec(3'b111, 1, 1, 32'h0, 1'b0);
        exec(OP_MV, 6, 1, 32'h0, 1'b0);
    endtask

    task automatic test_idle();
        exec(OP_MVI, 0, 0, 32'h1234, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, $urandom);
            @(posedge clk);
            @(negedge clk);
            #1;
            vectors++;
            if (cdone !== 1'b0 || cbus !== mreg[0]) begin
                miscompares++;
                $display("[TB] FAIL idle: got done=%b bus=%h expected 0 %h", cdone, cbus, mreg[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        exec(OP_MVI, 1, 0, 32'h0005, 1'b0);
        exec(OP_MVI, 2, 0, 32'h0003, 1'b0);
        drive(1'b1, encode(OP_ADD, 1, 2));
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, '0);
        @(posedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (cdone !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL done_in_t2: got %b expected 0", cdone);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (cdone !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL done_after_abort cycle %0d: got %b expected 0", i, cdone);
            end
            @(posedge clk);
            @(negedge clk);
        end
        compare_regs("abort");
        exec(OP_MV, 3, 0, 32'h0, 1'b0);
    endtask

    task automatic test_random(input int count);
        for (int n = 0; n < count; n++) begin
            exec(3'($urandom_range(0, 7)), $urandom_range(0, nregs() - 1),
                 $urandom_range(0, nregs() - 1), $urandom, 1'($urandom));
        end
    endtask

    task automatic test_wide();
        exec(OP_MVI, 15, 0, 32'hDEAD_BEEF, 1'b1);
        exec(OP_MV, 0, 15, 32'h0, 1'b1);
        set_dbg(0);
        #1;
        vectors++;
        if (cdbg !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("[TB] FAIL wide_mv_r0: got %h expected deadbeef", cdbg);
        end
        exec(OP_ADD, 0, 15, 32'h0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        run16 = 1'b0;
        run32 = 1'b0;
        din16 = '0;
        din32 = '0;
        dbg16 = '0;
        dbg32 = '0;
        model_reset();

        test_reset();
        test_basic();
        test_sub_wrap();
        test_mvnz();
        test_illegal();
        test_idle();
        test_reset_mid();
        test_random(40);

        wide = 1'b1;
        test_reset();
        test_wide();
        test_illegal();
        test_random(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
